// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the WISC instruction-fetch stage.
//   INSTR_W          instruction / address width
//   FETCH_RESET_PC   default PC loaded on reset
//   FETCH_NOP_INSTR  default encoding driven while no instruction is valid
//   PC_STEP          byte distance between sequential instructions
//   fetch_state_t    fetch sequencer states
package fetch_unit_pkg;

   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] FETCH_RESET_PC  = 16'h0000;
   localparam logic [INSTR_W-1:0] FETCH_NOP_INSTR = 16'h0800;
   localparam logic [INSTR_W-1:0] PC_STEP         = 16'h0002;

   typedef enum logic [2:0] {
      FETCH,
      DISCARD,
      FULL,
      HALTING,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/cla_16b.sv
// cla_16b: 16-bit two-level carry-lookahead adder (4-bit groups).
//   a, b   addends
//   c_in   carry into bit 0
//   sum    a + b + c_in, modulo 2^16 (carry out is not needed by the fetch stage)
module cla_16b
   import fetch_unit_pkg::*;
(
   input  logic [INSTR_W-1:0] a,
   input  logic [INSTR_W-1:0] b,
   input  logic               c_in,
   output logic [INSTR_W-1:0] sum
);

   logic [INSTR_W-1:0] g;
   logic [INSTR_W-1:0] p;
   logic [INSTR_W-1:0] c;
   logic [2:0]         gg;
   logic [2:0]         pg;
   logic [3:0]         gc;

   always_comb begin
      g = a & b;
      p = a ^ b;

      // Group generate/propagate; the top group's G/P would only feed carry out.
      for (int k = 0; k < 3; k++) begin
         gg[k] = g[4*k+3] | (p[4*k+3] & (g[4*k+2] | (p[4*k+2] &
                 (g[4*k+1] | (p[4*k+1] & g[4*k])))));
         pg[k] = &p[4*k +: 4];
      end

      gc[0] = c_in;
      gc[1] = gg[0] | (pg[0] & c_in);
      gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_in);
      gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) |
              (pg[2] & pg[1] & pg[0] & c_in);

      for (int k = 0; k < 4; k++) begin
         c[4*k] = gc[k];
         for (int j = 1; j < 4; j++) begin
            c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
         end
      end

      sum = p ^ c;
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit WISC pipeline.
// Holds the PC, handshakes with a variable-latency instruction memory,
// presents one instruction per cycle (with its PC+2) to decode through an
// output register backed by a one-entry skid buffer, and flushes wrong-path
// fetches on a redirect from execute.
//   clk, rst     clock; asynchronous active-low reset
//   PC_Next      redirect target from execute
//   Redirect     PC_Next valid (taken branch / jump)
//   Stall        decode cannot accept Instr this cycle
//   Halt         decode accepted a HALT this cycle
//   IMemRdy      memory returns IMemData this cycle
//   IMemData     instruction word from memory
//   IMemReq      fetch request, held until IMemRdy
//   IMemAddr     fetch address, stable while IMemReq=1
//   Instr        instruction to decode (NOP_INSTR when InstrValid=0)
//   PC_Out       PC+2 of Instr
//   InstrValid   Instr/PC_Out valid
//   Halted       sticky: fetch stopped
//   Err          sticky: misaligned redirect target seen
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = FETCH_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] PC_Next,
   input  logic               Redirect,
   input  logic               Stall,
   input  logic               Halt,
   input  logic               IMemRdy,
   input  logic [INSTR_W-1:0] IMemData,
   output logic               IMemReq,
   output logic [INSTR_W-1:0] IMemAddr,
   output logic [INSTR_W-1:0] Instr,
   output logic [INSTR_W-1:0] PC_Out,
   output logic               InstrValid,
   output logic               Halted,
   output logic               Err
);

   fetch_state_t state, state_nxt;

   logic [INSTR_W-1:0] pc, pc_nxt, pc_plus2;
   logic [INSTR_W-1:0] hold_addr, hold_addr_nxt;
   logic [INSTR_W-1:0] skid_instr_p0, skid_instr_p0_nxt;
   logic [INSTR_W-1:0] skid_pc_p0, skid_pc_p0_nxt;
   logic [INSTR_W-1:0] instr_p1, instr_p1_nxt;
   logic [INSTR_W-1:0] pc_out_p1, pc_out_p1_nxt;
   logic               vld_p1, vld_p1_nxt;
   logic               halted, halted_nxt;
   logic               err, err_nxt;

   logic req_active, pending, drain, can_load;
   logic redirect_ok, misaligned, stop;

   cla_16b u_pc_inc (
      .a    (pc),
      .b    (PC_STEP),
      .c_in (1'b0),
      .sum  (pc_plus2)
   );

   assign req_active  = (state == FETCH) || (state == DISCARD) || (state == HALTING);
   // A request whose response arrives this cycle is no longer outstanding.
   assign pending     = req_active && !IMemRdy;
   assign drain       = vld_p1 && !Stall;
   assign can_load    = !vld_p1 || drain;
   assign redirect_ok = Redirect && !PC_Next[0];
   assign misaligned  = Redirect && PC_Next[0];
   assign stop        = misaligned || (Halt && !Redirect);

   always_comb begin
      state_nxt         = state;
      pc_nxt            = pc;
      hold_addr_nxt     = hold_addr;
      skid_instr_p0_nxt = skid_instr_p0;
      skid_pc_p0_nxt    = skid_pc_p0;
      instr_p1_nxt      = instr_p1;
      pc_out_p1_nxt     = pc_out_p1;
      vld_p1_nxt        = vld_p1;
      halted_nxt        = halted;
      err_nxt           = err;

      if (drain) begin
         vld_p1_nxt   = 1'b0;
         instr_p1_nxt = NOP_INSTR;
      end

      case (state)
         HALTING: begin
            if (IMemRdy) begin
               state_nxt  = HALTED;
               halted_nxt = 1'b1;
            end
         end
         HALTED: ;
         default: begin
            if (redirect_ok) begin
               pc_nxt       = PC_Next;
               vld_p1_nxt   = 1'b0;
               instr_p1_nxt = NOP_INSTR;
               if (pending) begin
                  // The in-flight request keeps its address until its response is dropped.
                  if (state == FETCH) hold_addr_nxt = pc;
                  state_nxt = DISCARD;
               end else begin
                  state_nxt = FETCH;
               end
            end else if (stop) begin
               err_nxt      = err || misaligned;
               vld_p1_nxt   = 1'b0;
               instr_p1_nxt = NOP_INSTR;
               if (pending) begin
                  if (state == FETCH) hold_addr_nxt = pc;
                  state_nxt = HALTING;
               end else begin
                  state_nxt  = HALTED;
                  halted_nxt = 1'b1;
               end
            end else begin
               case (state)
                  FETCH: begin
                     if (IMemRdy) begin
                        pc_nxt = pc_plus2;
                        if (can_load) begin
                           instr_p1_nxt  = IMemData;
                           pc_out_p1_nxt = pc_plus2;
                           vld_p1_nxt    = 1'b1;
                        end else begin
                           skid_instr_p0_nxt = IMemData;
                           skid_pc_p0_nxt    = pc_plus2;
                           state_nxt         = FULL;
                        end
                     end
                  end
                  DISCARD: begin
                     if (IMemRdy) state_nxt = FETCH;
                  end
                  FULL: begin
                     if (drain) begin
                        instr_p1_nxt  = skid_instr_p0;
                        pc_out_p1_nxt = skid_pc_p0;
                        vld_p1_nxt    = 1'b1;
                        state_nxt     = FETCH;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         hold_addr     <= RESET_PC;
         skid_instr_p0 <= NOP_INSTR;
         skid_pc_p0    <= '0;
         instr_p1      <= NOP_INSTR;
         pc_out_p1     <= '0;
         vld_p1        <= 1'b0;
         halted        <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         hold_addr     <= hold_addr_nxt;
         // Stage p0 -> p1: skid entry feeds the decode-facing output register
         skid_instr_p0 <= skid_instr_p0_nxt;
         skid_pc_p0    <= skid_pc_p0_nxt;
         instr_p1      <= instr_p1_nxt;
         pc_out_p1     <= pc_out_p1_nxt;
         vld_p1        <= vld_p1_nxt;
         halted        <= halted_nxt;
         err           <= err_nxt;
      end
   end

   // Request is withdrawn combinationally while reset is held.
   assign IMemReq    = rst && req_active;
   assign IMemAddr   = ((state == DISCARD) || (state == HALTING)) ? hold_addr : pc;
   assign Instr      = instr_p1;
   assign PC_Out     = pc_out_p1;
   assign InstrValid = vld_p1;
   assign Halted     = halted;
   assign Err        = err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus pushes expected
// (Instr, PC_Out) pairs; a monitor pops and compares on every accepted output.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] PC_Next = '0;
   logic        Redirect = 1'b0;
   logic        Stall = 1'b0;
   logic        Halt = 1'b0;
   logic        IMemRdy = 1'b0;
   logic [15:0] IMemData = '0;
   logic        IMemReq;
   logic [15:0] IMemAddr;
   logic [15:0] Instr;
   logic [15:0] PC_Out;
   logic        InstrValid;
   logic        Halted;
   logic        Err;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .PC_Next    (PC_Next),
      .Redirect   (Redirect),
      .Stall      (Stall),
      .Halt       (Halt),
      .IMemRdy    (IMemRdy),
      .IMemData   (IMemData),
      .IMemReq    (IMemReq),
      .IMemAddr   (IMemAddr),
      .Instr      (Instr),
      .PC_Out     (PC_Out),
      .InstrValid (InstrValid),
      .Halted     (Halted),
      .Err        (Err)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   lat = 0;
   int   budget = 0;
   int   wcnt = 0;

   function automatic logic [15:0] memf(input logic [15:0] a);
      case (a)
         16'h0000: memf = 16'h1111;
         16'h0002: memf = 16'h2222;
         16'h0004: memf = 16'h3333;
         16'h0006: memf = 16'h4444;
         16'h0040: memf = 16'hAAAA;
         16'h0042: memf = 16'hBBBB;
         default:  memf = 16'h9000 | a;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] p);
      exp_t e;
      e.instr = i;
      e.pc    = p;
      sb.push_back(e);
   endtask

   // Memory model: answers a request after 'lat' waiting cycles, at most 'budget' times.
   always @(negedge clk) begin
      if (rst && IMemReq && wcnt >= lat && budget > 0) begin
         IMemRdy  = 1'b1;
         IMemData = memf(IMemAddr);
         budget   = budget - 1;
         wcnt     = 0;
      end else begin
         IMemRdy  = 1'b0;
         IMemData = 16'hDEAD;
         if (rst && IMemReq) wcnt = wcnt + 1;
         else wcnt = 0;
      end
   end

   // Monitor: an instruction counts as delivered when valid and not stalled.
   always @(negedge clk) begin
      #3;
      if (rst) begin
         if (!InstrValid) begin
            chk("nop_when_invalid", Instr, 16'h0800);
         end else if (!Stall) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_instr: got %h/%h expected none", Instr, PC_Out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("instr", Instr, e.instr);
               chk("pc_out", PC_Out, e.pc);
            end
         end
      end
   end

   task automatic do_reset();
      rst      = 1'b0;
      Redirect = 1'b0;
      Halt     = 1'b0;
      Stall    = 1'b0;
      PC_Next  = '0;
      budget   = 0;
      lat      = 0;
      repeat (2) tick();
      chk("rst_instr", Instr, 16'h0800);
      chk("rst_pc_out", PC_Out, 16'h0000);
      chk("rst_valid", 16'(InstrValid), 16'd0);
      chk("rst_halted", 16'(Halted), 16'd0);
      chk("rst_err", 16'(Err), 16'd0);
      chk("rst_req", 16'(IMemReq), 16'd0);
      sb.delete();
      rst = 1'b1;
      #1;
      chk("release_req", 16'(IMemReq), 16'd1);
      chk("release_addr", IMemAddr, 16'h0000);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!InstrValid && n < 20);
      chk({name, "_valid"}, 16'(InstrValid), 16'd1);
   endtask

   task automatic wait_sb_empty(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         tick();
         n++;
      end
      chk({name, "_drained"}, 16'(sb.size()), 16'd0);
   endtask

   task automatic wait_halted(input string name);
      int n = 0;
      while (!Halted && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_halted"}, 16'(Halted), 16'd1);
   endtask

   initial begin
      int waits;

      // Zero-latency streaming
      do_reset();
      lat = 0; budget = 3;
      push(16'h1111, 16'h0002); push(16'h2222, 16'h0004); push(16'h3333, 16'h0006);
      wait_valid("stream");
      tick(); chk("stream_cont1", 16'(InstrValid), 16'd1);
      tick(); chk("stream_cont2", 16'(InstrValid), 16'd1);
      wait_sb_empty("stream");
      repeat (2) tick();
      chk("stream_idle_valid", 16'(InstrValid), 16'd0);
      chk("stream_next_addr", IMemAddr, 16'h0006);
      chk("stream_next_req", 16'(IMemReq), 16'd1);

      // Variable latency: three waiting cycles, then the response cycle
      do_reset();
      lat = 3; budget = 1;
      push(16'h1111, 16'h0002);
      waits = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (InstrValid) break;
         waits++;
         chk("lat_addr_held", IMemAddr, 16'h0000);
         chk("lat_req_held", 16'(IMemReq), 16'd1);
      end
      chk("lat_wait_cycles", 16'(waits), 16'd4);
      wait_sb_empty("lat");

      // Stall: skid fills, request drops, order preserved
      do_reset();
      lat = 0; budget = 3;
      push(16'h1111, 16'h0002); push(16'h2222, 16'h0004); push(16'h3333, 16'h0006);
      wait_valid("stall");
      Stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_req_drop", 16'(IMemReq), 16'd0);
         chk("stall_hold_instr", Instr, 16'h1111);
      end
      Stall = 1'b0;
      tick(); chk("stall_release1", 16'(InstrValid), 16'd1);
      tick(); chk("stall_release2", 16'(InstrValid), 16'd1);
      wait_sb_empty("stall");

      // Redirect while the request to 0004 is outstanding
      do_reset();
      lat = 0; budget = 2;
      push(16'h1111, 16'h0002); push(16'h2222, 16'h0004); push(16'hAAAA, 16'h0042);
      waits = 0;
      while (!(IMemAddr == 16'h0004 && !InstrValid) && waits < 20) begin
         tick();
         waits++;
      end
      chk("redir_wait_addr", IMemAddr, 16'h0004);
      Redirect = 1'b1; PC_Next = 16'h0040; lat = 1; budget = 2;
      tick();
      Redirect = 1'b0;
      chk("redir_old_addr_stable", IMemAddr, 16'h0004);
      chk("redir_req_held", 16'(IMemReq), 16'd1);
      waits = 0;
      while (IMemAddr == 16'h0004 && waits < 20) begin
         tick();
         waits++;
      end
      chk("redir_new_addr", IMemAddr, 16'h0040);
      wait_sb_empty("redir");

      // Halt alone: outstanding response dropped, then halted for good
      do_reset();
      lat = 2; budget = 1;
      push(16'h1111, 16'h0002);
      wait_valid("halt");
      Halt = 1'b1; budget = 1;
      tick();
      Halt = 1'b0;
      chk("halting_req", 16'(IMemReq), 16'd1);
      chk("halting_not_yet", 16'(Halted), 16'd0);
      wait_halted("halt");
      budget = 4; Redirect = 1'b1; PC_Next = 16'h0040;
      tick();
      Redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halted_req_low", 16'(IMemReq), 16'd0);
         chk("halted_sticky", 16'(Halted), 16'd1);
         chk("halted_no_valid", 16'(InstrValid), 16'd0);
      end
      wait_sb_empty("halt");

      // Halt together with Redirect: redirect wins
      do_reset();
      lat = 0; budget = 1;
      push(16'h1111, 16'h0002); push(16'hAAAA, 16'h0042);
      wait_valid("prio");
      Halt = 1'b1; Redirect = 1'b1; PC_Next = 16'h0040; budget = 2;
      tick();
      Halt = 1'b0; Redirect = 1'b0;
      chk("prio_not_halted", 16'(Halted), 16'd0);
      waits = 0;
      while (IMemAddr == 16'h0002 && waits < 20) begin
         tick();
         waits++;
      end
      chk("prio_addr", IMemAddr, 16'h0040);
      chk("prio_still_running", 16'(Halted), 16'd0);
      wait_sb_empty("prio");

      // Misaligned redirect: error plus halt
      do_reset();
      lat = 0; budget = 1;
      push(16'h1111, 16'h0002);
      wait_valid("mis");
      Redirect = 1'b1; PC_Next = 16'h0101; budget = 1;
      tick();
      Redirect = 1'b0;
      chk("mis_err", 16'(Err), 16'd1);
      wait_halted("mis");
      chk("mis_err_sticky", 16'(Err), 16'd1);
      chk("mis_req_low", 16'(IMemReq), 16'd0);
      wait_sb_empty("mis");

      // Asynchronous reset while a request is waiting
      do_reset();
      Stall = 1'b1; lat = 0; budget = 1;
      wait_valid("arst");
      lat = 10; budget = 1;
      tick();
      chk("arst_pre_req", 16'(IMemReq), 16'd1);
      chk("arst_pre_addr", IMemAddr, 16'h0002);
      rst = 1'b0;
      #1;
      chk("arst_req", 16'(IMemReq), 16'd0);
      chk("arst_valid", 16'(InstrValid), 16'd0);
      chk("arst_instr", Instr, 16'h0800);
      chk("arst_pc_out", PC_Out, 16'h0000);
      do_reset();
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit WISC pipeline, directly upstream of decode/execute.
- Holds the architectural PC and runs a request/ready handshake to a variable-latency instruction memory.
- Presents one instruction per cycle, plus its PC+2, to decode. A one-entry skid buffer absorbs decode stalls.
- Consumes the execute stage's PC_Next on a taken branch or jump (Redirect), flushing and discarding wrong-path fetches.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding driven on Instr whenever InstrValid=0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset: rst=0 resets immediately, independent of clk.
- PC_Next  in  16  redirect target from execute.
- Redirect  in  1  PC_Next valid this cycle: branch taken or jump.
- Stall  in  1  decode cannot accept Instr this cycle.
- Halt  in  1  decode accepted a HALT this cycle.
- IMemRdy  in  1  instruction memory returns IMemData this cycle.
- IMemData  in  16  instruction word.
- IMemReq  out  1  fetch request; held until IMemRdy.
- IMemAddr  out  16  fetch address; stable while IMemReq=1.
- Instr  out  16  instruction to decode.
- PC_Out  out  16  PC+2 of Instr; this is execute's PC input.
- InstrValid  out  1  Instr/PC_Out valid.
- Halted  out  1  sticky: fetch stopped.
- Err  out  1  sticky: misaligned redirect target.

Behaviour:
- Reset values (asynchronous, rst=0):
  - PC=RESET_PC, state=FETCH, skid empty, Discard=0.
  - IMemReq=0 while rst=0.
  - Instr=NOP_INSTR, PC_Out=0, InstrValid=0, Halted=0, Err=0.
- First cycle after rst deasserts: IMemReq=1, IMemAddr=RESET_PC.
- States:
  - FETCH: IMemReq=1, IMemAddr=PC.
  - DISCARD: IMemReq=1, and the response will be dropped.
  - FULL: skid occupied, IMemReq=0.
  - HALTING: request outstanding; the response will be dropped.
  - HALTED: IMemReq=0 forever until reset.
- Output register:
  - It drains when InstrValid=1 and Stall=0.
  - It "can load" when InstrValid=0 or it is draining.
- Normal fetch:
  - A response is IMemRdy=1 in FETCH. On a response, PC<=PC+2.
  - If the output register can load: Instr<=IMemData, PC_Out<=PC+2, InstrValid<=1, and the state stays FETCH with the new address on the next cycle. Throughput is 1 instruction/cycle when IMemRdy is tied high.
  - Otherwise the response goes into the skid (with PC+2) and the state moves to FULL.
- FULL: when the output drains, skid -> output register, then FETCH. Program order is preserved: no drop, no duplicate.
- Draining with no new data loaded: InstrValid<=0, Instr<=NOP_INSTR.
- Redirect (highest priority; overrides Stall and Halt — execute's instruction is older):
  - PC<=PC_Next; InstrValid<=0; skid cleared.
  - If a request is outstanding and IMemRdy=0: go to DISCARD.
  - In DISCARD, the response is dropped, then the state returns to FETCH with IMemAddr=PC.
  - If IMemRdy=1 in the same cycle as Redirect: the data is dropped and the next cycle requests PC_Next.
  - From FULL: go to FETCH directly.
  - A Redirect while in DISCARD updates PC only; still exactly one response is dropped.
- Halt (no Redirect in the same cycle):
  - InstrValid<=0; skid cleared.
  - If a request is outstanding: go to HALTING. The response is dropped, then HALTED.
  - Otherwise go to HALTED directly.
  - Halted=1 on entry to HALTED.
  - Redirect and Halt are ignored in HALTING and HALTED.
- Misaligned redirect: Redirect with PC_Next[0]=1 sets Err=1 and is treated as a Halt (same HALTING/HALTED path); PC is not updated.
- Arithmetic: PC+2 is modulo 2^16; 16'hFFFE wraps to 16'h0000 with no flag.
- Reset mid-transaction: the state returns to reset values immediately. The memory must tolerate IMemReq being withdrawn, and any IMemRdy during reset is ignored.

Decomposition:
- Shared package:
  - State encoding (FETCH, DISCARD, FULL, HALTING, HALTED).
  - RESET_PC and NOP_INSTR constants.
  - Instruction width 16.
- Sub-module: the existing cla_16b instance computes PC+2 (b=16'h0002, c_in=0).
- The skid buffer stays inline (one entry).

Test Plan:
- Zero-latency streaming:
  - Stimulus: IMemRdy=1, mem[0]=16'h1111, mem[2]=16'h2222, mem[4]=16'h3333.
  - Response: after reset, consecutive cycles show Instr=1111/2222/3333 with PC_Out=0002/0004/0006, InstrValid continuously high.
- Variable latency:
  - Stimulus: IMemRdy after 3 cycles.
  - Response: IMemAddr=0000 held for 3 cycles, InstrValid=0 meanwhile. Instr=1111 with PC_Out=0002 appears the cycle after IMemRdy.
- Stall:
  - Stimulus: Stall=1 for 4 cycles while streaming.
  - Response: skid fills and IMemReq drops to 0. On release, Instr order is 1111, 2222, 3333 with no gap or duplicate.
- Redirect during wait:
  - Stimulus: Redirect=1 with PC_Next=0040 while a request to 0004 is outstanding.
  - Response: the 0004 data is never presented. The next IMemAddr is 0040, and the following Instr has PC_Out=0042.
- Halt and redirect priority:
  - Stimulus: Halt alone.
  - Response: Halted=1 after the outstanding response; IMemReq stays 0 thereafter.
  - Stimulus: Halt and Redirect in the same cycle.
  - Response: Halted stays 0 and IMemAddr=PC_Next.
- Misaligned redirect and reset:
  - Stimulus: Redirect with PC_Next=0101.
  - Response: Err=1 and Halted=1.
  - Stimulus: rst=0 asserted mid-WAIT.
  - Response: outputs are reset immediately (async). After release, IMemAddr=0000.
